// File: rtl/fft_pkg.sv
// Shared constants, controller state type and a single-cycle magnitude reference
// for the FFT spectrum writer.
package fft_pkg;

   localparam int FFT_LEN = 1024;
   localparam int DW      = 16;
   localparam int AW      = 9;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      CAPTURE,
      FLUSH,
      DONE,
      WAIT_LOW
   } fft_state_t;

   // Combinational form of the estimate; fft_mag_approx spreads it over two registers.
   function automatic logic [DW-1:0] mag_approx(input logic [DW-1:0] re,
                                                input logic [DW-1:0] im);
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      a = (re == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} : (re[DW-1] ? -re : re);
      b = (im == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} : (im[DW-1] ? -im : im);
      return (a > b) ? a + (b >> 1) : b + (a >> 1);
   endfunction

endpackage

// File: rtl/fft_ram_wr_mag.sv
// Two-stage |re|/|im| then max + min/2 magnitude estimate; the valid flag and
// bin index travel alongside the data so the consumer sees them aligned.
module fft_mag_approx #(
   parameter int DW = 16,
   parameter int BW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   input  logic [BW-1:0] in_bin,
   output logic          out_vld,
   output logic [DW-1:0] out_mag,
   output logic [BW-1:0] out_bin
);

   localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

   logic          s1_vld;
   logic [DW-1:0] s1_re;
   logic [DW-1:0] s1_im;
   logic [BW-1:0] s1_bin;
   logic [DW-1:0] abs_re;
   logic [DW-1:0] abs_im;

   // The most negative input has no positive twin, so it saturates.
   always_comb begin
      abs_re = (in_re == MIN_NEG) ? MAX_POS : (in_re[DW-1] ? -in_re : in_re);
      abs_im = (in_im == MIN_NEG) ? MAX_POS : (in_im[DW-1] ? -in_im : in_im);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_re   <= '0;
         s1_im   <= '0;
         s1_bin  <= '0;
         out_vld <= 1'b0;
         out_mag <= '0;
         out_bin <= '0;
      end else begin
         s1_vld  <= in_vld;
         s1_re   <= abs_re;
         s1_im   <= abs_im;
         s1_bin  <= in_bin;
         out_vld <= s1_vld;
         out_mag <= (s1_re > s1_im) ? s1_re + (s1_im >> 1) : s1_im + (s1_re >> 1);
         out_bin <= s1_bin;
      end
   end

endmodule

// File: rtl/fft_ram_wr.sv
// Captures one bin-0-aligned FFT frame, writes lower-half magnitudes to the
// spectrum RAM, tracks the peak non-DC bin and signals shutdown when done.
//
//   state    | meaning
//   IDLE     | not armed, waiting for fft_valid
//   SYNC     | discarding beats until bin 0 arrives
//   CAPTURE  | accepting bins in order, checking index and tlast
//   FLUSH    | two cycles for the magnitude pipeline to drain
//   DONE     | one cycle: shutdown + peak result
//   WAIT_LOW | holding off re-arm until fft_valid drops
module fft_ram_wr #(
   parameter int FFT_LEN = fft_pkg::FFT_LEN,
   parameter int DW      = fft_pkg::DW,
   parameter int AW      = fft_pkg::AW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fft_valid,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic [2*DW-1:0]            s_tdata,
   input  logic [$clog2(FFT_LEN)-1:0] s_tuser,
   input  logic                       s_tlast,
   output logic                       ram_we,
   output logic [AW-1:0]              ram_addr,
   output logic [DW-1:0]              ram_wdata,
   output logic                       fft_shutdown,
   output logic [AW-1:0]              peak_idx,
   output logic [DW-1:0]              peak_mag,
   output logic                       peak_vld,
   output logic                       frame_err
);

   import fft_pkg::*;

   localparam int BW = $clog2(FFT_LEN);

   fft_state_t    state;
   fft_state_t    state_nxt;
   logic [BW-1:0] exp_cnt;
   logic          flush_cnt;
   logic          accept;
   logic          pipe_in_vld;
   logic          err_nxt;
   logic          clr_peak;
   logic          at_last;

   logic          p_vld;
   logic [DW-1:0] p_mag;
   logic [BW-1:0] p_bin;
   logic          p_low_half;
   logic [DW-1:0] run_mag;
   logic [AW-1:0] run_idx;

   assign s_tready = (state == SYNC) || (state == CAPTURE);
   assign accept   = s_tvalid && s_tready;
   assign at_last  = &exp_cnt;

   always_comb begin
      state_nxt   = state;
      pipe_in_vld = 1'b0;
      err_nxt     = 1'b0;
      clr_peak    = 1'b0;
      unique case (state)
         IDLE: begin
            if (fft_valid) state_nxt = SYNC;
         end
         SYNC: begin
            if (!fft_valid) begin
               state_nxt = IDLE;
            end else if (accept && (s_tuser == '0)) begin
               pipe_in_vld = 1'b1;
               clr_peak    = 1'b1;
               state_nxt   = CAPTURE;
            end
         end
         CAPTURE: begin
            if (!fft_valid) begin
               state_nxt = IDLE;
            end else if (accept) begin
               if ((s_tuser != exp_cnt) || (s_tlast != at_last)) begin
                  err_nxt   = 1'b1;
                  state_nxt = SYNC;
               end else begin
                  pipe_in_vld = 1'b1;
                  if (at_last) state_nxt = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (!fft_valid)          state_nxt = IDLE;
            else if (flush_cnt == 1'b0) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!fft_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         exp_cnt   <= '0;
         flush_cnt <= 1'b1;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_err <= err_nxt;
         if (pipe_in_vld) exp_cnt <= s_tuser + BW'(1);
         if (state == FLUSH) flush_cnt <= flush_cnt - 1'b1;
         else                flush_cnt <= 1'b1;
      end
   end

   fft_mag_approx #(
      .DW (DW),
      .BW (BW)
   ) u_mag (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (pipe_in_vld),
      .in_re   (s_tdata[DW-1:0]),
      .in_im   (s_tdata[2*DW-1:DW]),
      .in_bin  (s_tuser),
      .out_vld (p_vld),
      .out_mag (p_mag),
      .out_bin (p_bin)
   );

   // Upper-half bins flow through the pipeline but never reach the RAM.
   assign p_low_half = ~p_bin[BW-1];
   assign ram_we     = p_vld && p_low_half;
   assign ram_addr   = p_bin[AW-1:0];
   assign ram_wdata  = p_mag;

   // Clear wins over update so stale results from an abandoned frame cannot leak in.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_mag  <= '0;
         run_idx  <= '0;
         peak_mag <= '0;
         peak_idx <= '0;
      end else begin
         if (clr_peak) begin
            run_mag <= '0;
            run_idx <= '0;
         end else if (ram_we && (p_bin != '0) && (p_mag > run_mag)) begin
            run_mag <= p_mag;
            run_idx <= p_bin[AW-1:0];
         end
         if ((state == FLUSH) && (state_nxt == DONE)) begin
            peak_mag <= run_mag;
            peak_idx <= run_idx;
         end
      end
   end

   assign fft_shutdown = (state == DONE);
   assign peak_vld     = (state == DONE);

endmodule

// File: doc/fft_ram_wr.md
Name: fft_ram_wr

Overview:
Downstream consumer of the FFT enable (`fft_valid`) and FFT output stream.
- Once armed, captures one complete FFT output frame aligned on bin 0.
- Writes an approximate magnitude for each bin in the lower half-spectrum into the spectrum RAM.
- Tracks the peak non-DC bin.
- When the frame is written, pulses `fft_shutdown` back to the FFT control stage, which then drops `fft_valid`.

Parameters:
- FFT_LEN, 1024: FFT points per frame; power of two, at least 8.
- DW, 16: width of each signed real/imag component; also the magnitude width.
- AW, 9: RAM address width, equal to log2(FFT_LEN/2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- fft_valid  in  1  capture enable from FFT control; level
- s_tvalid  in  1  FFT output beat valid
- s_tready  out  1  beat accept; high only in SYNC and CAPTURE
- s_tdata  in  2*DW  {imag, real}, two's complement
- s_tuser  in  log2(FFT_LEN)  bin index of the beat
- s_tlast  in  1  last beat of the frame
- ram_we  out  1  RAM write strobe
- ram_addr  out  AW  RAM write address, equal to the bin index
- ram_wdata  out  DW  unsigned magnitude
- fft_shutdown  out  1  one-cycle pulse: frame written to RAM
- peak_idx  out  AW  bin of the maximum magnitude in bins 1..FFT_LEN/2-1
- peak_mag  out  DW  magnitude at `peak_idx`
- peak_vld  out  1  one-cycle pulse, coincident with `fft_shutdown`
- frame_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; `s_tready` 0.
- A beat is accepted when `s_tvalid` and `s_tready` are both high.
- States:
  - IDLE: go to SYNC when `fft_valid` is 1.
  - SYNC: accept and discard beats until an accepted beat has `s_tuser`==0. That beat is processed as bin 0, and the state moves to CAPTURE with the expected counter set to 1.
  - CAPTURE: on each accepted beat, `s_tuser` must equal the expected counter, which then increments.
    - Index mismatch: pulse `frame_err` and return to SYNC. The mismatching beat is dropped, not re-examined for index 0.
    - `s_tlast` at an index other than FFT_LEN-1, or missing at FFT_LEN-1: pulse `frame_err` and return to SYNC.
    - Correct final beat: go to FLUSH.
  - FLUSH: 2 cycles while the pipeline drains, then DONE.
  - DONE: 1 cycle. `fft_shutdown`=1, `peak_vld`=1, `peak_idx`/`peak_mag` updated. Then go to WAIT_LOW.
  - WAIT_LOW: stay until `fft_valid`==0, then IDLE. This prevents re-arming before FFT control clears `fft_valid`.
- `fft_valid` falling in SYNC, CAPTURE or FLUSH: abort to IDLE on the next cycle.
  - No `fft_shutdown`, no `peak_vld`.
  - Pipeline writes already in flight still complete.
  - RAM holds a partial frame.
- Magnitude pipeline:
  - Stage 1 (cycle t+1): `|re|` and `|im|`; -2^(DW-1) saturates to 2^(DW-1)-1.
  - Stage 2 (cycle t+2): mag = max + (min>>1). The result is at most 1.5×(2^(DW-1)-1), so it fits DW bits unsigned with no overflow.
  - `ram_we` is asserted at t+2 only for captured bins below FFT_LEN/2; bins at or above FFT_LEN/2 are accepted and discarded.
  - `ram_addr` is the low AW bits of the bin; `ram_we` is high for exactly one cycle per written bin.
- Peak tracker:
  - Running max is cleared on entry to CAPTURE.
  - Updated from stage-2 results for bins 1..FFT_LEN/2-1; bin 0 is excluded.
  - Update only on strictly greater magnitude, so ties keep the lowest index.
  - Outputs are held between DONE pulses.
- Latency: last RAM write (bin FFT_LEN/2-1) occurs long before DONE; `fft_shutdown` occurs 3 cycles after the tlast beat is accepted.
- Back-to-back beats at full rate are supported; `s_tvalid` gaps are tolerated in every state.
- Reset mid-frame: immediate return to IDLE; pipeline valids cleared, so no stray `ram_we`.

Decomposition:
- Shared package `fft_pkg`:
  - FFT_LEN, DW, AW constants
  - state enum: IDLE, SYNC, CAPTURE, FLUSH, DONE, WAIT_LOW
  - function `mag_approx(re, im)`
- One sub-module: `fft_mag_approx`, the 2-stage abs/max-min pipeline carrying a valid flag and bin index alongside the data.
- FSM, counter and peak tracker live in the top.

Test Plan:
- Full-rate frame with FFT_LEN=16, re=k, im=-k for bin k (k=0..15, tuser=k, tlast at 15), `fft_valid`=1:
  - 8 writes, addr 0..7, wdata=k+(k>>1).
  - `fft_shutdown` and `peak_vld` pulse 3 cycles after beat 15.
  - peak_idx=7, peak_mag=10.
- Arm mid-frame: first beat has tuser=5. Beats 5..15 are discarded with no `ram_we`; the next frame from tuser=0 is captured normally with exactly one `fft_shutdown`.
- Index skip: tuser goes 0,1,3 → `frame_err` pulse on beat 3, no `fft_shutdown`; capture resumes at the next tuser=0.
- Early tlast at tuser=9 → `frame_err`, return to SYNC; tlast absent at tuser=15 → `frame_err`.
- Saturation: re=-32768, im=-32768 on bin 2 → wdata=49150; ties of equal magnitude on bins 3 and 6 → peak_idx=3.
- Aborts and re-arm:
  - `fft_valid` dropped at bin 4 → IDLE, no shutdown pulse.
  - `rst` asserted at bin 6 → all outputs 0 next cycle, no further `ram_we`.
  - `fft_valid` held high after DONE → stays in WAIT_LOW, no second capture.
